// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - branch condition kinds and resolve FSM states
package branch_resolve_unit_pkg;

  localparam logic [2:0] BR_EQZ    = 3'd0;
  localparam logic [2:0] BR_NEZ    = 3'd1;
  localparam logic [2:0] BR_LTZ    = 3'd2;
  localparam logic [2:0] BR_GEZ    = 3'd3;
  localparam logic [2:0] BR_EQ     = 3'd4;
  localparam logic [2:0] BR_NE     = 3'd5;
  localparam logic [2:0] BR_ALWAYS = 3'd6;
  localparam logic [2:0] BR_NEVER  = 3'd7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } br_state_t;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// rtl/branch_resolve_unit_cond_eval.sv - combinational branch condition evaluator
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        kind,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              cond
);

  // Sign comes from the MSB alone; no arithmetic is involved.
  always_comb begin
    cond = 1'b0;
    case (kind)
      BR_EQZ:    cond = (a == '0);
      BR_NEZ:    cond = (a != '0);
      BR_LTZ:    cond = a[DATA_W-1];
      BR_GEZ:    cond = ~a[DATA_W-1];
      BR_EQ:     cond = (a == b);
      BR_NE:     cond = (a != b);
      BR_ALWAYS: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch resolution with squash window and taken counter
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter int SQUASH_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_kind,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_taken,
  output logic [ADDR_W-1:0] out_target,
  output logic              squash,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  br_state_t  state;
  logic [3:0] sq_cnt;
  logic       cond;
  logic       accept;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .kind (in_kind),
    .a    (in_data_a),
    .b    (in_data_b),
    .cond (cond)
  );

  assign accept = in_valid & ~stall & ~flush & (state == ST_IDLE);
  assign squash = (SQUASH_CYCLES != 0) && (state == ST_SQUASH);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_taken   <= 1'b0;
      out_target  <= '0;
      taken_count <= '0;
      sq_cnt      <= '0;
      state       <= ST_IDLE;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_taken <= 1'b0;
      sq_cnt    <= '0;
      state     <= ST_IDLE;
    end else if (!stall) begin
      out_valid <= accept;
      out_taken <= accept & cond;
      if (accept) out_target <= in_target;
      if (accept && cond) begin
        if (taken_count != '1) taken_count <= taken_count + CNT_W'(1);
        if (SQUASH_CYCLES != 0) begin
          sq_cnt <= SQ_LOAD;
          state  <= ST_SQUASH;
        end
      end
      // Wrong-path inputs arriving during the window are simply not accepted.
      if (state == ST_SQUASH) begin
        sq_cnt <= sq_cnt - 4'd1;
        if (sq_cnt == 4'd1) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int SQ = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [2:0]  in_kind;
  logic [15:0] in_data_a, in_data_b, in_target;
  logic        out_valid, out_taken, squash;
  logic [15:0] out_target, taken_count;

  logic        v2;
  logic        ov2, ot2, sq2;
  logic [15:0] otg2;
  logic [3:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid, m_taken;
  logic [15:0] m_target;
  int          m_rem, m_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(16), .ADDR_W(16), .SQUASH_CYCLES(SQ), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_kind(in_kind),
    .in_data_a(in_data_a), .in_data_b(in_data_b), .in_target(in_target),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_taken(out_taken),
    .out_target(out_target), .squash(squash), .taken_count(taken_count)
  );

  branch_resolve_unit #(.DATA_W(16), .ADDR_W(16), .SQUASH_CYCLES(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(v2), .in_kind(3'd6),
    .in_data_a(16'h0000), .in_data_b(16'h0000), .in_target(16'h0040),
    .stall(1'b0), .flush(1'b0), .out_valid(ov2), .out_taken(ot2),
    .out_target(otg2), .squash(sq2), .taken_count(cnt2)
  );

  function automatic bit ref_cond(int k, logic [15:0] a, logic [15:0] b);
    case (k)
      0: return a == 0;
      1: return a != 0;
      2: return $signed(a) < 0;
      3: return $signed(a) >= 0;
      4: return a == b;
      5: return a != b;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle, advance the reference model, sample 1 time unit after the edge.
  task automatic step(bit r, bit iv, int k, logic [15:0] a, logic [15:0] b,
                      logic [15:0] tgt, bit st, bit fl);
    bit acc, c;
    rst = r; in_valid = iv; in_kind = 3'(k); in_data_a = a; in_data_b = b;
    in_target = tgt; stall = st; flush = fl;
    @(posedge clk);
    c = ref_cond(k, a, b);
    if (r) begin
      m_valid = 0; m_taken = 0; m_target = 0; m_rem = 0; m_count = 0;
    end else if (fl) begin
      m_valid = 0; m_taken = 0; m_rem = 0;
    end else if (!st) begin
      acc = iv && (m_rem == 0);
      if (m_rem > 0) m_rem--;
      m_valid = acc;
      m_taken = acc && c;
      if (acc) m_target = tgt;
      if (acc && c) begin
        if (m_count < 65535) m_count++;
        m_rem = SQ;
      end
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 7, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    v2 = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({out_valid, out_taken, squash} !== 3'b000 || out_target !== 16'h0 || taken_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: got v=%b t=%b sq=%b tgt=%h cnt=%h expected all zero", out_valid, out_taken, squash, out_target, taken_count);
    end
    n_tests++;
    if (cnt2 !== 4'h0 || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sat: got cnt=%h v=%b expected 0 0", cnt2, ov2);
    end
  endtask

  task automatic test_kinds;
    int          k[10]   = '{0, 0, 1, 1, 2, 3, 4, 5, 7, 3};
    logic [15:0] a[10]   = '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h7FFF, 16'h1234, 16'h1234, 16'h0000, 16'h8000};
    logic [15:0] b[10]   = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h1235, 16'h0, 16'h0};
    bit          exp[10] = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    int          cnt;
    for (int i = 0; i < 10; i++) begin
      cnt = m_count;
      step(0, 1, k[i], a[i], b[i], 16'(16'h100 + i), 0, 0);
      n_tests++;
      if (out_valid !== 1'b1 || out_taken !== exp[i] || out_target !== 16'(16'h100 + i)) begin
        n_fail++;
        $display("FAIL kind%0d_case%0d: got v=%b t=%b tgt=%h expected 1 %b %h", k[i], i, out_valid, out_taken, out_target, exp[i], 16'(16'h100 + i));
      end
      n_tests++;
      if (taken_count !== 16'(cnt + int'(exp[i]))) begin
        n_fail++;
        $display("FAIL count_case%0d: got %0d expected %0d", i, taken_count, cnt + int'(exp[i]));
      end
      idle(3);
    end
  endtask

  task automatic test_squash_window;
    int high = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 6, 0, 0, 16'h00A0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 16'h00A0) begin
      n_fail++;
      $display("FAIL squash_result: got v=%b t=%b tgt=%h expected 1 1 00a0", out_valid, out_taken, out_target);
    end
    if (squash === 1'b1) high++;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 0, 16'h0BAD, 0, 0);
      if (squash === 1'b1) high++;
      n_tests++;
      if (out_valid !== 1'b0 || taken_count !== 16'd1) begin
        n_fail++;
        $display("FAIL squash_drop%0d: got v=%b cnt=%0d expected 0 1", i, out_valid, taken_count);
      end
    end
    n_tests++;
    if (high != 2) begin
      n_fail++;
      $display("FAIL squash_len: got %0d cycles expected 2", high);
    end
    step(0, 1, 0, 0, 0, 16'h00B0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || taken_count !== 16'd2) begin
      n_fail++;
      $display("FAIL squash_after: got v=%b t=%b cnt=%0d expected 1 1 2", out_valid, out_taken, taken_count);
    end
    idle(3);
  endtask

  task automatic test_stall_flush;
    int high = 0;
    int guard = 0;
    int cnt;
    step(0, 1, 6, 0, 0, 16'h0C00, 0, 0);
    if (squash === 1'b1) high++;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 7, 0, 0, 0, 1, 0);
      if (squash === 1'b1) high++;
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_target !== 16'h0C00) begin
      n_fail++;
      $display("FAIL stall_hold: got v=%b tgt=%h expected 1 0c00", out_valid, out_target);
    end
    while (squash === 1'b1 && guard < 20) begin
      step(0, 0, 7, 0, 0, 0, 0, 0);
      if (squash === 1'b1) high++;
      guard++;
    end
    n_tests++;
    if (high != SQ + 3) begin
      n_fail++;
      $display("FAIL stall_extend: got %0d squash cycles expected %0d", high, SQ + 3);
    end
    idle(1);
    cnt = m_count;
    step(0, 1, 6, 0, 0, 16'h0D00, 0, 0);
    step(0, 1, 6, 0, 0, 16'h0E00, 1, 1);
    n_tests++;
    if (out_valid !== 1'b0 || squash !== 1'b0 || taken_count !== 16'(cnt + 1)) begin
      n_fail++;
      $display("FAIL flush: got v=%b sq=%b cnt=%0d expected 0 0 %0d", out_valid, squash, taken_count, cnt + 1);
    end
    step(0, 1, 1, 16'h0005, 0, 16'h0F00, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 16'h0F00) begin
      n_fail++;
      $display("FAIL after_flush: got v=%b t=%b tgt=%h expected 1 1 0f00", out_valid, out_taken, out_target);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_squash;
    step(0, 1, 6, 0, 0, 16'h1111, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || squash !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got v=%b sq=%b expected 1 1", out_valid, squash);
    end
    step(1, 1, 6, 0, 0, 16'h2222, 1, 0);
    n_tests++;
    if ({out_valid, out_taken, squash} !== 3'b000 || out_target !== 16'h0 || taken_count !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b t=%b sq=%b tgt=%h cnt=%h expected all zero", out_valid, out_taken, squash, out_target, taken_count);
    end
    step(0, 1, 0, 16'h0000, 0, 16'h3333, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || taken_count !== 16'd1 || out_target !== 16'h3333) begin
      n_fail++;
      $display("FAIL first_after_reset: got v=%b t=%b cnt=%0d tgt=%h expected 1 1 1 3333", out_valid, out_taken, taken_count, out_target);
    end
    idle(3);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++) begin
      v2 = 1;
      @(posedge clk);
      #1;
      n_tests++;
      if (ov2 !== 1'b1 || ot2 !== 1'b1 || sq2 !== 1'b0 || cnt2 !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
        n_fail++;
        $display("FAIL sat%0d: got v=%b t=%b sq=%b cnt=%0d expected 1 1 0 %0d", i, ov2, ot2, sq2, cnt2, (i + 1 > 15) ? 15 : i + 1);
      end
    end
    v2 = 0;
    @(posedge clk);
    #1;
    n_tests++;
    if (cnt2 !== 4'hF || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: got cnt=%h v=%b expected f 0", cnt2, ov2);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
           ($urandom_range(0, 1) == 0) ? in_data_a : 16'($urandom),
           16'($urandom), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
      n_tests++;
      if (out_valid !== m_valid || out_taken !== m_taken || out_target !== m_target ||
          squash !== (m_rem > 0) || taken_count !== 16'(m_count)) begin
        n_fail++;
        $display("FAIL random%0d: got v=%b t=%b tgt=%h sq=%b cnt=%0d expected %b %b %h %b %0d", i, out_valid, out_taken, out_target, squash, taken_count, m_valid, m_taken, m_target, m_rem > 0, m_count);
      end
    end
  endtask

  initial begin
    test_reset;
    test_kinds;
    test_squash_window;
    test_stall_flush;
    test_reset_mid_squash;
    test_saturation;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
